// File: rtl/csr_mfile.sv
// Machine-mode CSR file and trap controller: Zicsr accesses, trap entry/mret, M-mode interrupts.
// Optional macro CSR_COUNTERS_EN adds mcycle/minstret and a functional mcountinhibit.
module csr_mfile #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned HART_ID     = 0,
  parameter logic [63:0] MTVEC_RESET = 64'd0,
  parameter int unsigned EXT_M       = 1,
  parameter int unsigned CAUSE_W     = 5
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic [11:0]        csr_addr,
  input  logic [1:0]         csr_op,
  input  logic [XLEN-1:0]    csr_wdata,
  output logic [XLEN-1:0]    csr_rdata,
  output logic               csr_illegal,
  input  logic               trap_valid,
  input  logic               trap_is_int,
  input  logic [CAUSE_W-1:0] trap_cause,
  input  logic [XLEN-1:0]    trap_pc,
  input  logic [XLEN-1:0]    trap_tval,
  input  logic               mret,
  input  logic               inst_retire,
  input  logic               irq_ext,
  input  logic               irq_timer,
  input  logic               irq_soft,
  output logic               irq_req,
  output logic [CAUSE_W-1:0] irq_code,
  output logic [XLEN-1:0]    trap_vector,
  output logic [XLEN-1:0]    mepc_out
);

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MISA     = 12'h301;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MCNTINH  = 12'h320;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MTVAL    = 12'h343;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_MVENDOR  = 12'hF11;
  localparam logic [11:0] A_MARCH    = 12'hF12;
  localparam logic [11:0] A_MIMP     = 12'hF13;
  localparam logic [11:0] A_MHART    = 12'hF14;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MINSTRET = 12'hB02;
  localparam logic [11:0] A_MCYCLEH  = 12'hB80;
  localparam logic [11:0] A_MINSTRH  = 12'hB82;

  logic            mie_q, mie_d, mpie_q, mpie_d;
  logic [2:0]      ien_q, ien_d;   // {MEIE, MTIE, MSIE}
  logic [2:0]      ip_q, ip_d;     // {MEIP, MTIP, MSIP}
  logic [XLEN-1:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
`ifdef CSR_COUNTERS_EN
  logic [63:0]     mcycle_q, mcycle_d, minstret_q, minstret_d, wv64;
  logic            cy_q, cy_d, ir_q, ir_d;
`else
  logic            unused_ok;
  assign unused_ok = inst_retire;
`endif

  logic [XLEN-1:0] rdata_c, wval_c, mstatus_c, misa_c, mie_rd_c, mip_rd_c, base_c;
  logic            hit_c, wr_en_c;
  logic [2:0]      pend_c;

  // Read-only views of packed registers
  always_comb begin
    mstatus_c = '0;
    mstatus_c[12:11] = 2'b11;
    mstatus_c[7] = mpie_q;
    mstatus_c[3] = mie_q;
    misa_c = '0;
    misa_c[XLEN-1:XLEN-2] = (XLEN == 64) ? 2'd2 : 2'd1;
    misa_c[12] = (EXT_M != 0);
    misa_c[8] = 1'b1;
    mie_rd_c = '0;
    mie_rd_c[11] = ien_q[2];
    mie_rd_c[7] = ien_q[1];
    mie_rd_c[3] = ien_q[0];
    mip_rd_c = '0;
    mip_rd_c[11] = ip_q[2];
    mip_rd_c[7] = ip_q[1];
    mip_rd_c[3] = ip_q[0];
  end

  always_comb begin
    hit_c = 1'b1;
    rdata_c = '0;
    case (csr_addr)
      A_MSTATUS:  rdata_c = mstatus_c;
      A_MISA:     rdata_c = misa_c;
      A_MIE:      rdata_c = mie_rd_c;
      A_MTVEC:    rdata_c = mtvec_q;
      A_MSCRATCH: rdata_c = mscratch_q;
      A_MEPC:     rdata_c = mepc_q;
      A_MCAUSE:   rdata_c = mcause_q;
      A_MTVAL:    rdata_c = mtval_q;
      A_MIP:      rdata_c = mip_rd_c;
      A_MVENDOR, A_MARCH, A_MIMP: rdata_c = '0;
      A_MHART:    rdata_c = XLEN'(HART_ID);
`ifdef CSR_COUNTERS_EN
      A_MCNTINH: begin
        rdata_c[0] = cy_q;
        rdata_c[2] = ir_q;
      end
      A_MCYCLE:   rdata_c = XLEN'(mcycle_q);
      A_MINSTRET: rdata_c = XLEN'(minstret_q);
      A_MCYCLEH: begin
        rdata_c = XLEN'(mcycle_q[63:32]);
        hit_c = (XLEN == 32);
      end
      A_MINSTRH: begin
        rdata_c = XLEN'(minstret_q[63:32]);
        hit_c = (XLEN == 32);
      end
`else
      A_MCNTINH:  rdata_c = '0;
`endif
      default:    hit_c = 1'b0;
    endcase
  end

  always_comb begin
    case (csr_op)
      2'b01:   wval_c = csr_wdata;
      2'b10:   wval_c = rdata_c | csr_wdata;
      2'b11:   wval_c = rdata_c & ~csr_wdata;
      default: wval_c = rdata_c;
    endcase
  end

  assign csr_rdata   = rdata_c;
  assign csr_illegal = (csr_op != 2'b00) &&
                       (!hit_c || ((csr_addr[11:10] == 2'b11) && ((csr_op == 2'b01) || (|csr_wdata))));
  assign wr_en_c     = (csr_op != 2'b00) && !csr_illegal && ((csr_op == 2'b01) || (|csr_wdata));

  // Interrupt arbitration: MEI > MSI > MTI
  assign pend_c  = ip_q & ien_q;
  assign irq_req = mie_q & (|pend_c);
  always_comb begin
    if (pend_c[2])      irq_code = CAUSE_W'(11);
    else if (pend_c[0]) irq_code = CAUSE_W'(3);
    else if (pend_c[1]) irq_code = CAUSE_W'(7);
    else                irq_code = '0;
  end

  assign base_c      = {mtvec_q[XLEN-1:2], 2'b00};
  assign trap_vector = ((mtvec_q[1:0] == 2'b01) && trap_is_int) ? base_c + (XLEN'(trap_cause) << 2) : base_c;
  assign mepc_out    = mepc_q;

  // Next state: CSR write, then mret, then trap; later assignments win
  always_comb begin
    mie_d = mie_q;
    mpie_d = mpie_q;
    ien_d = ien_q;
    ip_d = {irq_ext, irq_timer, irq_soft};
    mtvec_d = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d = mepc_q;
    mcause_d = mcause_q;
    mtval_d = mtval_q;
`ifdef CSR_COUNTERS_EN
    wv64 = 64'(wval_c);
    cy_d = cy_q;
    ir_d = ir_q;
    mcycle_d = cy_q ? mcycle_q : mcycle_q + 64'd1;
    minstret_d = (inst_retire && !ir_q) ? minstret_q + 64'd1 : minstret_q;
`endif
    if (wr_en_c) begin
      case (csr_addr)
        A_MSTATUS: begin
          mie_d = wval_c[3];
          mpie_d = wval_c[7];
        end
        A_MIE:      ien_d = {wval_c[11], wval_c[7], wval_c[3]};
        A_MTVEC:    mtvec_d = {wval_c[XLEN-1:2], wval_c[1] ? mtvec_q[1:0] : wval_c[1:0]};
        A_MSCRATCH: mscratch_d = wval_c;
        A_MEPC:     mepc_d = {wval_c[XLEN-1:2], 2'b00};
        A_MCAUSE:   mcause_d = wval_c;
        A_MTVAL:    mtval_d = wval_c;
`ifdef CSR_COUNTERS_EN
        A_MCNTINH: begin
          cy_d = wval_c[0];
          ir_d = wval_c[2];
        end
        A_MCYCLE:   mcycle_d = (XLEN == 64) ? wv64 : {mcycle_q[63:32], wv64[31:0]};
        A_MINSTRET: minstret_d = (XLEN == 64) ? wv64 : {minstret_q[63:32], wv64[31:0]};
        A_MCYCLEH:  mcycle_d = {wv64[31:0], mcycle_q[31:0]};
        A_MINSTRH:  minstret_d = {wv64[31:0], minstret_q[31:0]};
`endif
        default: ;
      endcase
    end
    if (mret) begin
      mie_d = mpie_q;
      mpie_d = 1'b1;
    end
    if (trap_valid) begin
      mepc_d = {trap_pc[XLEN-1:2], 2'b00};
      mcause_d = {trap_is_int, (XLEN-1)'(trap_cause)};
      mtval_d = trap_tval;
      mpie_d = mie_q;
      mie_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      mie_q <= 1'b0;
      mpie_q <= 1'b0;
      ien_q <= '0;
      ip_q <= '0;
      mtvec_q <= XLEN'(MTVEC_RESET);
      mscratch_q <= '0;
      mepc_q <= '0;
      mcause_q <= '0;
      mtval_q <= '0;
`ifdef CSR_COUNTERS_EN
      mcycle_q <= '0;
      minstret_q <= '0;
      cy_q <= 1'b0;
      ir_q <= 1'b0;
`endif
    end else begin
      mie_q <= mie_d;
      mpie_q <= mpie_d;
      ien_q <= ien_d;
      ip_q <= ip_d;
      mtvec_q <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q <= mepc_d;
      mcause_q <= mcause_d;
      mtval_q <= mtval_d;
`ifdef CSR_COUNTERS_EN
      mcycle_q <= mcycle_d;
      minstret_q <= minstret_d;
      cy_q <= cy_d;
      ir_q <= ir_d;
`endif
    end
  end

endmodule

// File: tb/tb_csr_mfile.sv
// Directed self-checking bench for csr_mfile (XLEN=32, HART_ID=3).
module tb_csr_mfile;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic [11:0] csr_addr = '0;
  logic [1:0]  csr_op = '0;
  logic [31:0] csr_wdata = '0;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        trap_valid = 1'b0, trap_is_int = 1'b0, mret = 1'b0, inst_retire = 1'b0;
  logic [4:0]  trap_cause = '0;
  logic [31:0] trap_pc = '0, trap_tval = '0;
  logic        irq_ext = 1'b0, irq_timer = 1'b0, irq_soft = 1'b0;
  logic        irq_req;
  logic [4:0]  irq_code;
  logic [31:0] trap_vector, mepc_out;

  int n_vec = 0;
  int n_err = 0;

  csr_mfile #(.XLEN(32), .HART_ID(3), .MTVEC_RESET(64'd0), .EXT_M(1), .CAUSE_W(5)) dut (
    .clk(clk), .n_rst(n_rst), .csr_addr(csr_addr), .csr_op(csr_op), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .csr_illegal(csr_illegal), .trap_valid(trap_valid),
    .trap_is_int(trap_is_int), .trap_cause(trap_cause), .trap_pc(trap_pc), .trap_tval(trap_tval),
    .mret(mret), .inst_retire(inst_retire), .irq_ext(irq_ext), .irq_timer(irq_timer),
    .irq_soft(irq_soft), .irq_req(irq_req), .irq_code(irq_code), .trap_vector(trap_vector),
    .mepc_out(mepc_out)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
    csr_addr = a;
    csr_op = 2'b00;
    #1;
    check_vec(tag, 64'(csr_rdata), 64'(exp));
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
    csr_addr = a;
    csr_op = op;
    csr_wdata = d;
    step();
    csr_op = 2'b00;
    csr_wdata = '0;
  endtask

  initial begin
    step();
    step();
    n_rst = 1'b1;
    #1;
    check_vec("rst_irq_req", 64'(irq_req), 64'd0);
    check_vec("rst_mepc", 64'(mepc_out), 64'd0);
    rd_chk("rst_mstatus", 12'h300, 32'h1800);
    rd_chk("misa", 12'h301, 32'h4000_1100);
    rd_chk("mhartid", 12'hF14, 32'h3);
    rd_chk("rst_mtvec", 12'h305, 32'h0);

    // mtvec WARL mode
    csr_wr(12'h305, 2'b01, 32'h1001);
    rd_chk("mtvec_vec", 12'h305, 32'h1001);
    csr_wr(12'h305, 2'b01, 32'h2002);
    rd_chk("mtvec_keep_mode", 12'h305, 32'h2001);
    csr_wr(12'h305, 2'b01, 32'h1001);

    // mie WARL, then interrupt enable path
    csr_wr(12'h304, 2'b01, 32'hFFFF);
    rd_chk("mie_warl", 12'h304, 32'h888);
    irq_ext = 1'b1;
    csr_wr(12'h304, 2'b01, 32'h800);
    check_vec("irq_masked_by_mie", 64'(irq_req), 64'd0);
    check_vec("irq_code_pending", 64'(irq_code), 64'd11);
    csr_wr(12'h300, 2'b10, 32'h8);
    check_vec("irq_req_on", 64'(irq_req), 64'd1);
    check_vec("irq_code_mei", 64'(irq_code), 64'd11);
    rd_chk("mstatus_mie", 12'h300, 32'h1808);

    // Interrupt trap entry
    trap_valid = 1'b1; trap_is_int = 1'b1; trap_cause = 5'd11; trap_pc = 32'h206; trap_tval = 32'h77;
    #1;
    check_vec("vector_int", 64'(trap_vector), 64'h102C);
    step();
    trap_valid = 1'b0;
    check_vec("trap_mepc", 64'(mepc_out), 64'h204);
    rd_chk("trap_mcause", 12'h342, 32'h8000_000B);
    rd_chk("trap_mstatus", 12'h300, 32'h1880);
    rd_chk("trap_mtval", 12'h343, 32'h77);
    check_vec("trap_irq_off", 64'(irq_req), 64'd0);
    trap_is_int = 1'b0;
    #1;
    check_vec("vector_exc", 64'(trap_vector), 64'h1000);

    // mret
    mret = 1'b1;
    step();
    mret = 1'b0;
    rd_chk("mret_mstatus", 12'h300, 32'h1888);
    check_vec("mret_mepc", 64'(mepc_out), 64'h204);

    // Same-cycle priority
    trap_valid = 1'b1; trap_cause = 5'd2; trap_pc = 32'h300; trap_tval = 32'h0;
    csr_wr(12'h300, 2'b01, 32'h8);
    rd_chk("prio_trap_mstatus", 12'h300, 32'h1880);
    trap_pc = 32'h310;
    csr_wr(12'h340, 2'b01, 32'h55);
    trap_valid = 1'b0;
    rd_chk("prio_mscratch", 12'h340, 32'h55);
    rd_chk("prio_mstatus2", 12'h300, 32'h1800);
    mret = 1'b1;
    csr_wr(12'h300, 2'b01, 32'h8);
    mret = 1'b0;
    rd_chk("prio_mret_mstatus", 12'h300, 32'h1880);
    trap_valid = 1'b1; trap_pc = 32'h320;
    csr_wr(12'h341, 2'b01, 32'h999);
    trap_valid = 1'b0;
    check_vec("prio_trap_mepc", 64'(mepc_out), 64'h320);

    // Plain RMW and mepc alignment
    csr_wr(12'h340, 2'b11, 32'h5);
    rd_chk("csrrc_mscratch", 12'h340, 32'h50);
    csr_wr(12'h341, 2'b01, 32'h123);
    check_vec("mepc_align", 64'(mepc_out), 64'h120);

    // Illegal accesses
    csr_addr = 12'hF11; csr_op = 2'b01; csr_wdata = 32'h5;
    #1;
    check_vec("ill_ro_write", 64'(csr_illegal), 64'd1);
    step();
    rd_chk("ro_unchanged", 12'hF11, 32'h0);
    csr_addr = 12'hF11; csr_op = 2'b10; csr_wdata = 32'h0;
    #1;
    check_vec("ro_set_zero_legal", 64'(csr_illegal), 64'd0);
    check_vec("ro_set_zero_rd", 64'(csr_rdata), 64'd0);
    csr_addr = 12'h7C0; csr_op = 2'b01;
    #1;
    check_vec("ill_unimpl", 64'(csr_illegal), 64'd1);
    csr_op = 2'b00;

    // mip latency and priority ordering
    rd_chk("mip_ext", 12'h344, 32'h800);
    csr_wr(12'h300, 2'b10, 32'h8);
    irq_timer = 1'b1; irq_soft = 1'b1;
    csr_wr(12'h304, 2'b01, 32'h888);
    check_vec("code_all", 64'(irq_code), 64'd11);
    irq_ext = 1'b0;
    #1;
    check_vec("code_latency", 64'(irq_code), 64'd11);
    step();
    check_vec("code_msi", 64'(irq_code), 64'd3);
    check_vec("req_msi", 64'(irq_req), 64'd1);
    irq_soft = 1'b0;
    step();
    check_vec("code_mti", 64'(irq_code), 64'd7);
    irq_timer = 1'b0;
    step();
    check_vec("code_none", 64'(irq_code), 64'd0);
    check_vec("req_none", 64'(irq_req), 64'd0);

`ifdef CSR_COUNTERS_EN
    csr_wr(12'h320, 2'b01, 32'h4);
    rd_chk("mcountinhibit", 12'h320, 32'h4);
    inst_retire = 1'b1;
    repeat (5) step();
    inst_retire = 1'b0;
    rd_chk("minstret_inhibit", 12'hB02, 32'h0);
    csr_wr(12'h320, 2'b01, 32'h0);
    inst_retire = 1'b1;
    repeat (3) step();
    inst_retire = 1'b0;
    rd_chk("minstret_count", 12'hB02, 32'h3);
    csr_wr(12'h320, 2'b01, 32'h1);
    csr_wr(12'hB80, 2'b01, 32'h0);
    csr_wr(12'hB00, 2'b01, 32'd100);
    repeat (3) step();
    rd_chk("mcycle_inhibit", 12'hB00, 32'd100);
    csr_wr(12'h320, 2'b01, 32'h0);
    csr_wr(12'hB00, 2'b01, 32'hFFFF_FFFF);
    csr_wr(12'hB80, 2'b01, 32'hFFFF_FFFF);
    rd_chk("mcycle_max_lo", 12'hB00, 32'hFFFF_FFFF);
    step();
    rd_chk("mcycle_wrap_lo", 12'hB00, 32'h0);
    rd_chk("mcycle_wrap_hi", 12'hB80, 32'h0);
`else
    csr_addr = 12'hB00; csr_op = 2'b10; csr_wdata = 32'h0;
    #1;
    check_vec("ill_no_counter", 64'(csr_illegal), 64'd1);
    csr_op = 2'b00;
    csr_wr(12'h320, 2'b01, 32'h5);
    rd_chk("mcountinhibit_zero", 12'h320, 32'h0);
`endif

    // Reset wins over a concurrent trap
    trap_valid = 1'b1; trap_pc = 32'h400; n_rst = 1'b0;
    step();
    trap_valid = 1'b0; n_rst = 1'b1;
    check_vec("rst_over_trap_mepc", 64'(mepc_out), 64'h0);
    rd_chk("rst_over_trap_mstatus", 12'h300, 32'h1800);
    rd_chk("rst_over_trap_mtvec", 12'h305, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/csr_mfile.md
Name: csr_mfile

Overview:
Parametrised machine-mode CSR register file and trap controller for the CPU-X core. Holds the M-mode CSRs and serves the pipeline's Zicsr read/modify/write accesses. Performs trap entry and mret state updates, prioritises the three M-mode interrupt sources, and produces the trap-vector redirect PC. Sits beside the execute stage; trap, mret and retire strobes come from the pipeline's commit point.

Parameters:
XLEN, 32, data width; 32 or 64 only.
HART_ID, 0, value returned by mhartid.
MTVEC_RESET, 0, reset value of mtvec; bits [1:0] give the reset mode.
EXT_M, 1, when 1, the misa M bit reads as 1.
CAUSE_W, 5, width of the trap cause code input.

Ports:
clk  in  1  clock
n_rst  in  1  synchronous active-low reset
csr_addr  in  12  CSR address
csr_op  in  2  00 none, 01 write (CSRRW), 10 set (CSRRS), 11 clear (CSRRC)
csr_wdata  in  XLEN  write, set or clear operand
csr_rdata  out  XLEN  combinational read of csr_addr (the old value)
csr_illegal  out  1  access faults (combinational)
trap_valid  in  1  take a trap this cycle
trap_is_int  in  1  trap is an interrupt
trap_cause  in  CAUSE_W  exception or interrupt code
trap_pc  in  XLEN  PC of the faulting or interrupted instruction
trap_tval  in  XLEN  mtval payload
mret  in  1  mret commits
inst_retire  in  1  one instruction retired
irq_ext, irq_timer, irq_soft  in  1 each  raw MEI, MTI and MSI levels
irq_req  out  1  enabled interrupt pending
irq_code  out  CAUSE_W  code of the highest-priority pending interrupt
trap_vector  out  XLEN  redirect target
mepc_out  out  XLEN  current mepc, used as the mret target

Behaviour:
- Reset is synchronous and active-low. n_rst=0 at a rising clk edge sets:
  - mstatus = 0x1800 (MPP=11, MIE=0, MPIE=0);
  - mie, mscratch, mepc, mcause, mtval, mip flops and counters = 0;
  - mtvec = MTVEC_RESET.
  - Outputs follow from these values: irq_req=0.
- Reset asserted mid-trap overrides the trap strobe.
- Read-only registers:
  - misa: MXL=1 for XLEN=32, 2 for XLEN=64; I bit set; M bit set if EXT_M.
  - mvendorid, marchid and mimpid read as 0.
  - mhartid reads as HART_ID.
- Addresses: mstatus 0x300, misa 0x301, mie 0x304, mtvec 0x305, mcountinhibit 0x320, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343, mip 0x344, mvendorid..mhartid 0xF11..0xF14.
- CSR write value: new = wdata (op 01), old|wdata (10), old&~wdata (11). It is committed at the next clk edge; csr_rdata shows the old value in the same cycle.
- csr_illegal=1 when csr_op≠00 and either:
  - the address is unimplemented; or
  - csr_addr[11:10]==11 and the op writes. Op 01 always writes; ops 10/11 write only when csr_wdata≠0.
  When csr_illegal=1, no state changes.
- WARL rules:
  - mstatus: only MIE, MPIE and MPP are writable; MPP always reads 11.
  - mie: only bits 11, 7 and 3 are writable.
  - mtvec: a mode of 2 or 3 keeps the previous mode.
  - mepc: bits [1:0] are forced to 0.
  - mip: fully read-only. MEIP, MTIP and MSIP are the irq_* inputs registered once (one-cycle latency).
- Interrupts: pend = mip & mie.
  - irq_req = mstatus.MIE & |pend.
  - Priority MEI(11) > MSI(3) > MTI(7); irq_code is the winning code.
  - irq_code = 0 when no interrupt is pending.
- Trap entry (trap_valid=1), applied at the clk edge:
  - mepc = trap_pc with [1:0] cleared;
  - mcause = {trap_is_int, zero-extended trap_cause};
  - mtval = trap_tval;
  - MPIE = MIE, MIE = 0, MPP = 11.
- trap_vector (combinational):
  - {mtvec[XLEN-1:2],2'b00} in direct mode;
  - in vectored mode with trap_is_int=1: that base + 4*trap_cause;
  - exceptions always use the base.
- mret (applied at the clk edge): MIE = MPIE, MPIE = 1, MPP = 11.
- Same-cycle priority: trap_valid > mret > CSR write.
  - A lower-priority event that changes the same register is dropped.
  - A CSR write to a register the trap does not touch (e.g. mscratch) still commits.

Optional Feature:
Macro CSR_COUNTERS_EN.
- Defined: implements 64-bit mcycle (0xB00) and minstret (0xB02); for XLEN=32, the upper halves at 0xB80/0xB82. mcountinhibit implements bit 0 (CY) and bit 2 (IR).
  - mcycle increments every clk unless CY is set.
  - minstret increments on inst_retire unless IR is set.
  - Both wrap from 2^64-1 to 0.
  - A CSR write to any half in a cycle replaces that cycle's increment for the whole counter (the other half holds).
- Undefined: these addresses are unimplemented (csr_illegal=1), and mcountinhibit reads as 0 with writes ignored.

Test Plan:
- Reset, then read 0x300, 0x301 and 0xF14 (HART_ID=3, XLEN=32) -> 0x1800, 0x40001100, 0x3.
- Write mtvec=0x1001; irq_ext=1, mie=0x800, MIE=1 -> irq_req=1 two cycles later with irq_code=11. Then trap_valid with trap_is_int=1, trap_cause=11, trap_pc=0x206 -> trap_vector=0x102C; next cycle mepc=0x204, mcause=0x8000000B, MIE=0, MPIE=1.
- mret the cycle after the previous case -> MIE=1, MPIE=1; mepc_out stays 0x204.
- Same cycle: trap_valid plus CSRRW mstatus=0x8, plus CSRRW mscratch=0x55 -> MIE=0 (trap wins), mscratch=0x55.
- CSRRW to 0xF11 -> csr_illegal=1, no change. CSRRS 0xF11 with wdata=0 -> legal, reads 0. CSRRW 0x7C0 -> illegal.
- With CSR_COUNTERS_EN: set mcycle low=0xFFFFFFFF, mcycleh=0xFFFFFFFF -> next idle cycle reads 0/0 (wrap). Set mcountinhibit=0x4 and retire 5 instructions -> minstret unchanged.
